// File: rtl/rv32_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word behind a small output FIFO.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module rv32_encoder #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    // DEPTH is expected to be a power of two so the pointers wrap for free.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0] enc_word;
    logic        enc_err;
    logic        opc_bad;
    logic        is_shift;
    logic [6:0]  funct7;

    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    assign funct7   = in_alt ? 7'h20 : 7'h00;

    always_comb begin
        enc_word = NOP_WORD;
        opc_bad  = 1'b0;
        case (in_opcode)
            OPC_LUI, OPC_AUIPC: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
            end
            OPC_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            end
            OPC_JALR, OPC_LOAD: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    enc_word = {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                end
            end
            OPC_STORE: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            OPC_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
            end
            OPC_OP: begin
                enc_word = {funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            default: begin
                enc_word = NOP_WORD;
                opc_bad  = 1'b1;
            end
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic fits_i;
    logic fits_b;
    logic fits_j;
    logic range_bad;

    // A value fits N signed bits when bits [31:N-1] are all copies of the sign.
    assign fits_i = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign fits_b = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign fits_j = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

    always_comb begin
        range_bad = 1'b0;
        case (in_opcode)
            OPC_LUI, OPC_AUIPC: range_bad = (in_imm[11:0] != '0);
            OPC_JAL:            range_bad = !fits_j || in_imm[0];
            OPC_JALR, OPC_LOAD: range_bad = !fits_i;
            OPC_OP_IMM:         range_bad = is_shift ? (in_imm[31:5] != '0) : !fits_i;
            OPC_STORE:          range_bad = !fits_i;
            OPC_BRANCH:         range_bad = !fits_b || in_imm[0];
            default:            range_bad = 1'b0;
        endcase
    end

    assign enc_err = opc_bad || range_bad;
`else
    assign enc_err = opc_bad;
`endif

    logic [31:0]   word_mem [DEPTH];
    logic          err_mem  [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          push;
    logic          pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // Registered from next-state count, so out_ready never reaches in_ready combinationally.
        in_ready_d = (count_d < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Storage needs no reset: only entries behind a valid count are ever exposed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            word_mem[wr_ptr_q] <= enc_word;
            err_mem[wr_ptr_q]  <= enc_err;
        end
    end

    assign out_instr = out_valid ? word_mem[rd_ptr_q] : '0;
    assign out_err   = out_valid ? err_mem[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_rv32_encoder.sv
// Directed self-checking bench for rv32_encoder (DEPTH=2); expected err on range
// violations follows whether ENC_RANGE_CHECK_EN is defined.
module tb_rv32_encoder;

    localparam int unsigned DEPTH = 2;
`ifdef ENC_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    int n_checks;
    int n_errors;

    rv32_encoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
        in_opcode = op;
        in_funct3 = f3;
        in_alt    = alt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    // Push one instruction into an empty FIFO and check it appears the next cycle.
    task automatic enc_one(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm,
                           input logic [31:0] exp_word, input logic exp_err);
        @(negedge clk);
        set_fields(op, f3, alt, rd, rs1, rs2, imm);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_eq({tag, "_in_ready"}, in_ready, 1'b1);
        check_eq({tag, "_empty"}, out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_word"}, out_instr, exp_word);
        check_eq({tag, "_err"}, out_err, exp_err);
    endtask

    logic [31:0] q[$];
    int          sent;
    int          recv;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_fields(7'h00, 3'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_word", out_instr, 32'h0);
        check_eq("rst_err", out_err, 1'b0);

        // Directed encodings
        enc_one("addi", 7'h13, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        enc_one("sub",  7'h33, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
        enc_one("sw",   7'h23, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
        enc_one("jal",  7'h6F, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 1'b0);
        enc_one("lui",  7'h37, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000,
                32'h1234_52B7, 1'b0);
        enc_one("beq",  7'h63, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd16, 32'h0020_8863, 1'b0);
        enc_one("srai", 7'h13, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 32'h4031_5093, 1'b0);
        enc_one("lw",   7'h03, 3'b010, 1'b0, 5'd4, 5'd3, 5'd0, 32'hFFFF_FFFC,
                32'hFFC1_A203, 1'b0);
        enc_one("badop", 7'h7F, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0000_0013, 1'b1);
        // Range boundaries: err only when checking is built in
        enc_one("addi_rng", 7'h13, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 32'h8000_0093, RC);
        enc_one("addi_neg", 7'h13, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800,
                32'h8000_0093, 1'b0);
        enc_one("lui_rng", 7'h37, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5678,
                32'h1234_52B7, RC);
        enc_one("slli_rng", 7'h13, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 32'd33, 32'h0011_1093, RC);
        enc_one("beq_odd", 7'h63, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0020_8163, RC);

        // Backpressure: three back-to-back offers into DEPTH=2 with the consumer stalled
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(7'h13, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        check_eq("bp_ready1", in_ready, 1'b1);
        set_fields(7'h33, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        check_eq("bp_full_ready", in_ready, 1'b0);
        set_fields(7'h23, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        repeat (2) @(negedge clk);
        check_eq("bp_hold_ready", in_ready, 1'b0);
        check_eq("bp_hold_word", out_instr, 32'h0050_0093);
        out_ready = 1'b1;
        check_eq("bp_head_a", out_instr, 32'h0050_0093);
        @(negedge clk);
        check_eq("bp_ready_back", in_ready, 1'b1);
        check_eq("bp_head_b", out_instr, 32'h4020_81B3);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_head_c_valid", out_valid, 1'b1);
        check_eq("bp_head_c", out_instr, 32'h0020_A423);
        @(negedge clk);
        check_eq("bp_drained", out_valid, 1'b0);

        // Streaming with mixed stalls; model occupancy via an expected-word queue
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            int  pre;
            logic m_ready;
            @(negedge clk);
            out_ready = (cyc >= 4) && ((cyc % 5) != 2);
            in_valid  = (sent < 16);
            set_fields(7'h13, 3'b000, 1'b0, 5'(sent), 5'd0, 5'd0, 32'(sent));
            pre     = q.size();
            m_ready = (pre < DEPTH);
            check_eq("st_valid", out_valid, (pre != 0));
            check_eq("st_ready", in_ready, m_ready);
            if (pre != 0 && out_ready) begin
                check_eq("st_word", out_instr, q.pop_front());
                recv++;
            end
            if (in_valid && m_ready) begin
                q.push_back((32'(sent) << 20) | (32'(sent) << 7) | 32'h13);
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("st_recv", recv, 16);
        check_eq("st_empty", out_valid, 1'b0);

        // Reset with two entries queued and an input offered in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(7'h13, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'd1);
        repeat (2) @(negedge clk);
        check_eq("pre_rst_full", in_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_fields(7'h37, 3'b000, 1'b0, 5'd9, 5'd0, 5'd0, 32'hABCD_E000);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // The cycle-after-reset push lands here; confirm reset itself discarded everything
        check_eq("mid_rst_word_new", out_instr, 32'hABCD_E4B7);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_word", out_instr, 32'h0);
        check_eq("mid_rst_err", out_err, 1'b0);
        check_eq("mid_rst_ready", in_ready, 1'b1);
        enc_one("post_rst", 7'h33, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
